// File: rtl/rom_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the ROM burst reader:
//   - state_e            : FSM state encoding (IDLE / STREAM)
//   - ROM_DEFAULT_DEPTH  : number of populated words in the default image
//   - ROM_IMAGE          : contents of the default ROM image (16-bit words)
// ---------------------------------------------------------------------------
package rom_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam int ROM_DEFAULT_DEPTH = 25;

  localparam logic [15:0] ROM_IMAGE [ROM_DEFAULT_DEPTH] = '{
    16'd2,   16'd0,   16'd104, 16'd2,   16'd12,
    16'd7,   16'd33,  16'd5,   16'd91,  16'd17,
    16'd200, 16'd64,  16'd3,   16'd250, 16'd18,
    16'd77,  16'd1,   16'd129, 16'd45,  16'd60,
    16'd99,  16'd8,   16'd150, 16'd36,  16'd145
  };

endpackage

// File: rtl/rom_table.sv
// ---------------------------------------------------------------------------
// rom_table
// Combinational lookup into the default ROM image.
// Ports:
//   addr  in   ADDR_W  word address
//   data  out  DATA_W  word at addr, or 0 when addr is outside the populated
//                      range (>= DEPTH, or beyond the stored image)
// ---------------------------------------------------------------------------
module rom_table
  import rom_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = ROM_DEFAULT_DEPTH
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // A DEPTH larger than the stored image leaves the extra words reading zero.
  localparam int POP_LIMIT = (DEPTH < ROM_DEFAULT_DEPTH) ? DEPTH : ROM_DEFAULT_DEPTH;

  logic [31:0] addr_ext;

  always_comb begin
    addr_ext = 32'(addr);
    data     = '0;
    if (addr_ext < 32'(POP_LIMIT)) begin
      data = DATA_W'(ROM_IMAGE[addr_ext[4:0]]);
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// ---------------------------------------------------------------------------
// rom_burst_reader
// Accepts a burst request (start address + length-1) and streams consecutive
// ROM words through a registered valid/ready output stage.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   request handshake (ready only while idle)
//   REQ_ADDR, REQ_LEN     first word address, words in burst minus one
//   OUT, OUT_VALID        registered read data and its valid flag
//   OUT_READY             consumer accepts the presented word
//   OUT_LAST              final word of the burst (qualified by OUT_VALID)
//   BUSY                  burst in progress
// ---------------------------------------------------------------------------
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = ROM_DEFAULT_DEPTH,
  parameter int LEN_W  = 8,
  parameter int WRAP   = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [LEN_W-1:0]  REQ_LEN,
  output logic [DATA_W-1:0] OUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_data;

  // With WRAP set, the populated window is circular; otherwise the address
  // simply rolls over at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (WRAP != 0 && 32'(a) == 32'(DEPTH - 1)) begin
      return '0;
    end
    return a + ADDR_W'(1);
  endfunction

  rom_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rom_table (
    .addr (rd_addr),
    .data (rd_data)
  );

  // The first word is loaded on the acceptance edge itself, so the table is
  // addressed straight from the request while idle. cnt_q holds the count
  // belonging to the next word to load; that word is last when it is zero.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_addr     = (state_q == ST_IDLE) ? REQ_ADDR : addr_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          state_d     = ST_STREAM;
          out_d       = rd_data;
          out_valid_d = 1'b1;
          out_last_d  = (REQ_LEN == '0);
          addr_d      = next_addr(REQ_ADDR);
          cnt_d       = REQ_LEN - LEN_W'(1);
        end
      end
      ST_STREAM: begin
        if (out_valid_q && OUT_READY && out_last_q) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (!out_last_q && (!out_valid_q || OUT_READY)) begin
          out_d       = rd_data;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == '0);
          addr_d      = next_addr(addr_q);
          cnt_d       = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset wins over everything, dropping any burst in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Ready is masked by RST so no request can be accepted in the reset cycle.
  assign REQ_READY = (state_q == ST_IDLE) && !RST;
  assign BUSY      = (state_q == ST_STREAM);
  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_burst_reader
// Drives two readers (WRAP = 0 and WRAP = 1) with identical stimulus and
// compares their streams against a word-list reference model, plus directed
// timing checks on the single-word, streaming, backpressure, end-of-table,
// reset and busy-request scenarios.
// ---------------------------------------------------------------------------
module tb_rom_burst_reader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 25;

  localparam logic [15:0] IMAGE [25] = '{
    16'd2,   16'd0,   16'd104, 16'd2,   16'd12,
    16'd7,   16'd33,  16'd5,   16'd91,  16'd17,
    16'd200, 16'd64,  16'd3,   16'd250, 16'd18,
    16'd77,  16'd1,   16'd129, 16'd45,  16'd60,
    16'd99,  16'd8,   16'd150, 16'd36,  16'd145
  };

  logic              CLK = 1'b0;
  logic              RST;
  logic              REQ_VALID;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [LEN_W-1:0]  REQ_LEN;
  logic              OUT_READY = 1'b1;

  logic              req_ready0, req_ready1;
  logic [DATA_W-1:0] out0, out1;
  logic              out_valid0, out_valid1;
  logic              out_last0, out_last1;
  logic              busy0, busy1;

  int   check_count = 0;
  int   error_count = 0;
  int   ready_mode  = 0;
  logic manual_ready = 1'b1;

  logic [DATA_W:0] exp_q0 [$];
  logic [DATA_W:0] exp_q1 [$];

  always #5 CLK = ~CLK;

  rom_burst_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .WRAP(0)
  ) dut0 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(req_ready0),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .OUT(out0), .OUT_VALID(out_valid0),
    .OUT_READY(OUT_READY), .OUT_LAST(out_last0), .BUSY(busy0)
  );

  rom_burst_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .WRAP(1)
  ) dut1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(req_ready1),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .OUT(out1), .OUT_VALID(out_valid1),
    .OUT_READY(OUT_READY), .OUT_LAST(out_last1), .BUSY(busy1)
  );

  // Consumer readiness: always ready, random, or scripted by the main flow.
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = ($urandom_range(0, 3) != 0);
      default: OUT_READY = manual_ready;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_word(input int a);
    return (a < DEPTH) ? DATA_W'(IMAGE[a]) : '0;
  endfunction

  // Expected word list for a burst, once per wrap flavour.
  task automatic push_model(input int addr, input int len);
    int a0 = addr;
    int a1 = addr;
    for (int i = 0; i <= len; i++) begin
      exp_q0.push_back({(i == len), model_word(a0)});
      exp_q1.push_back({(i == len), model_word(a1)});
      a0 = (a0 + 1) % 65536;
      a1 = (a1 == DEPTH - 1) ? 0 : (a1 + 1) % 65536;
    end
  endtask

  logic prev_stall [2] = '{1'b0, 1'b0};

  task automatic score_dut(input int d, input logic valid, input logic last,
                           input logic [DATA_W-1:0] data);
    logic [DATA_W:0] e;
    logic have;
    if (prev_stall[d]) checkOutput("valid held under stall", valid, 1);
    if (valid && OUT_READY) begin
      have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      checkOutput("word expected", have, 1);
      if (have) begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        checkOutput((d == 0) ? "stream data wrap0" : "stream data wrap1", data, e[DATA_W-1:0]);
        checkOutput((d == 0) ? "stream last wrap0" : "stream last wrap1", last, e[DATA_W]);
      end
    end
    prev_stall[d] = valid && !OUT_READY;
  endtask

  // Scoreboard: every handshaken word is matched against the model in order.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q0.delete();
      exp_q1.delete();
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      score_dut(0, out_valid0, out_last0, out0);
      score_dut(1, out_valid1, out_last1, out1);
    end
  end

  task automatic applyStimulus(input int addr, input int len);
    int waited = 0;
    while (!req_ready0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("request ready", req_ready0, 1);
    if (req_ready0) begin
      REQ_VALID = 1'b1;
      REQ_ADDR  = ADDR_W'(addr);
      REQ_LEN   = LEN_W'(len);
      push_model(addr, len);
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy0 || busy1) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("burst drained",
                (exp_q0.size() == 0 && exp_q1.size() == 0 && !busy0 && !busy1) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] exp37 [5]  = '{16'd2, 16'd0, 16'd104, 16'd2, 16'd12};
    logic [15:0] exp39a [4] = '{16'd36, 16'd145, 16'd0, 16'd0};
    logic [15:0] exp39b [4] = '{16'd36, 16'd145, 16'd2, 16'd0};
    int wait_cnt;
    int addr;

    RST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_ADDR = '0;
    REQ_LEN = '0;
    $display("[TB] reset");
    repeat (3) @(negedge CLK);
    checkOutput("reset req_ready", req_ready0, 0);
    checkOutput("reset out_valid", out_valid0, 0);
    checkOutput("reset out_last", out_last0, 0);
    checkOutput("reset out", out0, 0);
    checkOutput("reset busy", busy0, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("ready after reset", req_ready0, 1);

    $display("[TB] single word");
    applyStimulus(2, 0);
    @(negedge CLK);
    checkOutput("single data", out0, 104);
    checkOutput("single valid", out_valid0, 1);
    checkOutput("single last", out_last0, 1);
    @(negedge CLK);
    checkOutput("single ready back", req_ready0, 1);
    checkOutput("single valid drop", out_valid0, 0);

    $display("[TB] streaming");
    applyStimulus(0, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("stream valid", out_valid0, 1);
      checkOutput("stream word", out0, exp37[i]);
      checkOutput("stream last flag", out_last0, (i == 4) ? 1 : 0);
    end
    wait_drain();

    $display("[TB] backpressure");
    ready_mode = 2;
    manual_ready = 1'b1;
    applyStimulus(0, 2);
    @(negedge CLK);
    checkOutput("bp word0", out0, 2);
    manual_ready = 1'b0;
    @(negedge CLK);
    checkOutput("bp word1", out0, 0);
    checkOutput("bp word1 valid", out_valid0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checkOutput("bp hold data", out0, 0);
      checkOutput("bp hold valid", out_valid0, 1);
    end
    manual_ready = 1'b1;
    @(negedge CLK);
    checkOutput("bp word1 released", out0, 0);
    @(negedge CLK);
    checkOutput("bp word2", out0, 104);
    checkOutput("bp word2 last", out_last0, 1);
    wait_drain();
    ready_mode = 0;

    $display("[TB] end of table");
    applyStimulus(23, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("eot wrap0", out0, exp39a[i]);
      checkOutput("eot wrap1", out1, exp39b[i]);
    end
    wait_drain();

    $display("[TB] reset mid-burst");
    applyStimulus(0, 7);
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    checkOutput("mid reset ready low", req_ready0, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("post reset valid", out_valid0, 0);
    checkOutput("post reset out", out0, 0);
    checkOutput("post reset last", out_last0, 0);
    checkOutput("post reset busy", busy0, 0);
    checkOutput("post reset ready", req_ready0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("no word after reset", out_valid0 | out_valid1, 0);
    end

    $display("[TB] busy request");
    applyStimulus(0, 5);
    REQ_VALID = 1'b1;
    REQ_ADDR  = 16'd4;
    REQ_LEN   = '0;
    wait_cnt = 0;
    do begin
      @(negedge CLK);
      wait_cnt++;
    end while (!req_ready0 && wait_cnt < 50);
    checkOutput("busy request wait", wait_cnt, 7);
    if (req_ready0) push_model(4, 0);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("busy request data", out0, 12);
    checkOutput("busy request last", out_last0, 1);
    wait_drain();

    $display("[TB] random bursts");
    ready_mode = 1;
    for (int n = 0; n < 24; n++) begin
      addr = ($urandom_range(0, 3) == 0) ? 65530 + $urandom_range(0, 5)
                                         : $urandom_range(0, 30);
      applyStimulus(addr, $urandom_range(0, 10));
      wait_drain();
    end
    ready_mode = 0;

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 SHALL take parameter DATA_W, default 16: width of each ROM word.
REQ-002 SHALL take parameter ADDR_W, default 16: width of the word address.
REQ-003 SHALL take parameter DEPTH, default 25: number of populated words; addresses >= DEPTH are unpopulated.
REQ-004 SHALL take parameter LEN_W, default 8: width of the burst-length field.
REQ-005 SHALL take parameter WRAP, default 0: 0 = unpopulated addresses read as zero; 1 = address wraps to 0 after DEPTH-1.
REQ-006 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-007 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port REQ_VALID  input  1  burst request present.
REQ-009 SHALL have port REQ_READY  output  1  block accepts a request this cycle.
REQ-010 SHALL have port REQ_ADDR  input  ADDR_W  first word address.
REQ-011 SHALL have port REQ_LEN  input  LEN_W  words in the burst minus one (0 = one word).
REQ-012 SHALL have port OUT  output  DATA_W  read data.
REQ-013 SHALL have port OUT_VALID  output  1  OUT holds a valid word.
REQ-014 SHALL have port OUT_READY  input  1  consumer accepts the word.
REQ-015 SHALL have port OUT_LAST  output  1  marks the final word of a burst; qualified by OUT_VALID.
REQ-016 SHALL have port BUSY  output  1  burst in progress (state STREAM).

Function
REQ-017 SHALL implement FSM states IDLE and STREAM; REQ_READY = 1 only in IDLE.
REQ-018 SHALL accept a request on a cycle with REQ_VALID & REQ_READY, latch the address and the remaining count, and enter STREAM.
REQ-019 SHALL present the first word with OUT_VALID = 1 exactly one cycle after acceptance (registered output).
REQ-020 SHALL load the output register only when OUT_VALID = 0 or OUT_READY = 1; otherwise OUT, OUT_VALID and OUT_LAST SHALL hold unchanged.
REQ-021 SHALL sustain one word per cycle while OUT_READY stays high.
REQ-022 SHALL advance the address and decrement the count by one on each output-register load.
REQ-023 SHALL assert OUT_LAST with the word loaded when the remaining count is 0.
REQ-024 SHALL return to IDLE on the edge where the OUT_LAST word is handshaken; REQ_READY SHALL rise in the following cycle.
REQ-025 SHALL drop OUT_VALID after the last handshake unless a new word is loaded.
REQ-026 SHALL return 0 for any address >= DEPTH when WRAP = 0; the address SHALL wrap modulo 2^ADDR_W.
REQ-027 SHALL wrap the next address from DEPTH-1 to 0 when WRAP = 1; a start address >= DEPTH SHALL read 0 until it wraps.
REQ-028 SHALL ignore REQ_VALID while in STREAM, with no queuing.
REQ-029 SHALL never drop or duplicate a word under any OUT_READY pattern.

Reset
REQ-030 SHALL, while RST = 1 at a rising edge, force state IDLE, OUT_VALID = 0, OUT_LAST = 0, OUT = 0, BUSY = 0, and clear the address and count registers.
REQ-031 SHALL abandon any burst in flight on reset; no word from that burst SHALL appear after reset deasserts.
REQ-032 SHALL hold REQ_READY = 0 during the reset cycle and raise it on the first cycle after reset.

Structure
REQ-033 SHALL put the FSM state encoding, the default image constants and the DEPTH default in shared package rom_pkg.
REQ-034 SHALL contain one sub-module, rom_table: combinational lookup, parameterised by DATA_W, ADDR_W and DEPTH, returning 0 for out-of-range addresses.
REQ-035 SHALL use this default image in rom_table: 25 words, including word0 = 2, word2 = 104, word4 = 12, word23 = 36 and word24 = 145.

Verification
REQ-036 SHALL test a single word: ADDR = 2, LEN = 0, OUT_READY = 1 -> next cycle OUT = 104, OUT_VALID = 1, OUT_LAST = 1; REQ_READY high 2 cycles after acceptance.
REQ-037 SHALL test streaming: ADDR = 0, LEN = 4, OUT_READY = 1 -> OUT = 2, 0, 104, 2, 12 on 5 consecutive cycles, OUT_LAST on the 5th word only.
REQ-038 SHALL test backpressure: ADDR = 0, LEN = 2, OUT_READY low on the 2nd word for 3 cycles -> OUT holds 0 and OUT_VALID stays high; the sequence is 2, 0, 104 with no loss.
REQ-039 SHALL test end of table: ADDR = 23, LEN = 3 -> WRAP = 0 gives 36, 145, 0, 0; WRAP = 1 gives 36, 145, 2, 0.
REQ-040 SHALL test reset mid-burst: RST pulsed one cycle during word 3 of an ADDR = 0, LEN = 7 burst -> OUT_VALID = 0 the next cycle, REQ_READY = 1 the cycle after, no further words.
REQ-041 SHALL test a busy request: REQ_VALID held high during STREAM with ADDR = 4 -> ignored until IDLE, then accepted and returns 12.
